// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB software register bank.
// Holds the slave FSM encoding and the OPB byte-enable to bit-mask mapping.
package opb_reg_pkg;

  localparam int OPB_DWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    ERR  = 2'd2,
    WAIT = 2'd3
  } opb_state_e;

  // be[3] carries OPB_BE[0], which owns the most significant byte (bits 31:24)
  function automatic logic [OPB_DWIDTH-1:0] be_to_mask(input logic [3:0] be);
    logic [OPB_DWIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// OPB slave address decode and handshake FSM: one xferAck/errAck per select,
// issued the cycle after select is first seen, re-armed only once select drops.
module opb_slave_decode
  import opb_reg_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = '0,
  parameter logic [AWIDTH-1:0] HIGHADDR = '1,
  parameter int NUM_REGS = 8,
  parameter int IDX_W = 3
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic              select,
  input  logic              rnw,
  output logic              ack,
  output logic              err_ack,
  output logic [IDX_W-1:0]  idx_p1,
  output logic              rnw_p1
);

  opb_state_e        state;
  logic              hit;
  logic              in_range;
  logic [AWIDTH-1:0] word;

  assign hit      = select && (addr >= BASEADDR) && (addr <= HIGHADDR);
  assign word     = (addr - BASEADDR) >> 2;
  assign in_range = word < AWIDTH'(NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (hit) state <= in_range ? ACK : ERR;
        ACK:     state <= WAIT;
        ERR:     state <= WAIT;
        WAIT:    if (!select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: transfer attributes captured when the request is accepted
  always_ff @(posedge clk) begin
    if (state == IDLE && hit) begin
      idx_p1 <= word[IDX_W-1:0];
      rnw_p1 <= rnw;
    end
  end

  assign ack     = (state == ACK);
  assign err_ack = (state == ERR);

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS 32-bit PPC-writable registers on OPB with per-register
// write strobes and optional self-clearing (pulse/command) registers.
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR     = 32'h0118_0100,
  parameter logic [31:0] C_HIGHADDR     = 32'h0118_01FF,
  parameter int          C_OPB_AWIDTH   = 32,
  parameter int          C_OPB_DWIDTH   = OPB_DWIDTH,
  parameter int          C_NUM_REGS     = 8,
  parameter logic [31:0] C_RESET_VAL    = 32'h0,
  parameter logic [63:0] C_SELFCLR_MASK = 64'h0,
  parameter              C_FAMILY       = "virtex6"
)(
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:3]                   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  output logic                         Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]     user_data_out,
  output logic [C_NUM_REGS-1:0]        user_wr_strb
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int unused_family_bits = $bits(C_FAMILY);

  logic [OPB_DWIDTH-1:0] regs [C_NUM_REGS];
  logic                  ack;
  logic                  err_ack;
  logic [IDX_W-1:0]      idx_p1;
  logic                  rnw_p1;
  logic                  wr_en;
  logic [OPB_DWIDTH-1:0] wdata;
  logic [OPB_DWIDTH-1:0] wmask;
  logic                  unused_ok;

  assign unused_ok = OPB_seqAddr;

  opb_slave_decode #(
    .AWIDTH   (C_OPB_AWIDTH),
    .BASEADDR (C_BASEADDR),
    .HIGHADDR (C_HIGHADDR),
    .NUM_REGS (C_NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_decode (
    .clk     (OPB_Clk),
    .rst     (OPB_Rst),
    .addr    (OPB_ABus),
    .select  (OPB_select),
    .rnw     (OPB_RNW),
    .ack     (ack),
    .err_ack (err_ack),
    .idx_p1  (idx_p1),
    .rnw_p1  (rnw_p1)
  );

  assign wr_en = ack && !rnw_p1;
  assign wdata = OPB_DBus;
  assign wmask = be_to_mask(OPB_BE);

  // Stage p2: register update and strobe; a write in the same cycle beats a pending self-clear
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs[i] <= C_RESET_VAL;
      end
      user_wr_strb <= '0;
    end else begin
      user_wr_strb <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (C_SELFCLR_MASK[i] && user_wr_strb[i]) begin
          regs[i] <= C_RESET_VAL;
        end
      end
      if (wr_en) begin
        regs[idx_p1]         <= (regs[idx_p1] & ~wmask) | (wdata & wmask);
        user_wr_strb[idx_p1] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

  // Zero outside the ack cycle so the slave can share the wired-OR OPB data bus
  assign Sl_DBus    = (ack && rnw_p1) ? regs[idx_p1] : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = err_ack;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for the OPB register bank: directed cases plus random
// transfers compared against a per-register array model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE    = 32'h0118_0100;
  localparam logic [31:0] HIGH    = 32'h0118_01FF;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0000;
  localparam int          N       = 8;
  localparam logic [63:0] SCMASK  = 64'h8;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:31]      abus;
  logic [0:3]       be;
  logic [0:31]      dbus;
  logic             rnw;
  logic             sel;
  logic             seq;
  logic [0:31]      sl_dbus;
  logic             sl_err;
  logic             sl_retry;
  logic             sl_tout;
  logic             sl_ack;
  logic [32*N-1:0]  udo;
  logic [N-1:0]     strb;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [N];

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR     (BASE),
    .C_HIGHADDR     (HIGH),
    .C_OPB_AWIDTH   (32),
    .C_OPB_DWIDTH   (32),
    .C_NUM_REGS     (N),
    .C_RESET_VAL    (RST_VAL),
    .C_SELFCLR_MASK (SCMASK),
    .C_FAMILY       ("virtex6")
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .Sl_xferAck    (sl_ack),
    .user_data_out (udo),
    .user_wr_strb  (strb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = RST_VAL;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Compare every bus output and every register word against the model
  task automatic check_cycle(input string pfx, input bit exp_ack, input bit exp_err,
                             input logic [31:0] exp_dbus, input logic [N-1:0] exp_strb);
    chk({pfx, "_xferack"}, 64'(sl_ack), 64'(exp_ack));
    chk({pfx, "_errack"},  64'(sl_err), 64'(exp_err));
    chk({pfx, "_dbus"},    64'(sl_dbus), 64'(exp_dbus));
    chk({pfx, "_tied"},    64'({sl_retry, sl_tout}), 64'(0));
    chk({pfx, "_strb"},    64'(strb), 64'(exp_strb));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_reg%0d", pfx, i), 64'(udo[32*i +: 32]), 64'(model[i]));
  endtask

  // One OPB transfer; caller enters just after a rising edge. Select is held
  // for `hold` extra cycles past the natural drop point to probe re-triggering.
  task automatic xfer(input logic [31:0] addr, input bit rd, input logic [31:0] data,
                      input logic [3:0] ben, input int hold);
    bit          hit, ok, err;
    int          idx;
    logic [N-1:0] s;
    logic [31:0] rdexp;
    hit = ({32'h0, addr} >= {32'h0, BASE}) && ({32'h0, addr} <= {32'h0, HIGH});
    idx = hit ? int'((addr - BASE) >> 2) : 0;
    ok  = hit && (idx < N);
    err = hit && !ok;
    abus = addr; rnw = rd; dbus = data; be = ben; sel = 1'b1;
    @(negedge clk);
    check_cycle("c0", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    @(negedge clk);
    rdexp = (ok && rd) ? model[idx] : 32'h0;
    check_cycle("c1", ok, err, rdexp, '0);
    if (ok && !rd) model[idx] = merge(model[idx], data, ben);
    @(posedge clk); #1;
    if (hold == 0) sel = 1'b0;
    @(negedge clk);
    s = '0;
    if (ok && !rd) s[idx] = 1'b1;
    check_cycle("c2", 1'b0, 1'b0, 32'h0, s);
    if (ok && !rd && SCMASK[idx]) model[idx] = RST_VAL;
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk); #1;
      if (h == hold) sel = 1'b0;
      @(negedge clk);
      check_cycle("hold", 1'b0, 1'b0, 32'h0, '0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_cycle("c3", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rnw = 1'b1; seq = 1'b0;
    abus = '0; dbus = '0; be = '0;
    model_reset();
    @(negedge clk);
    check_cycle("reset", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cycle("postrst", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;

    xfer(BASE + 32'h8, 1'b0, 32'hDEAD_BEEF, 4'b1111, 0);
    chk("reg2_full", 64'(udo[64 +: 32]), 64'h0000_0000_DEAD_BEEF);
    xfer(BASE + 32'h8, 1'b0, 32'h1122_3344, 4'b0101, 0);
    chk("reg2_be", 64'(udo[64 +: 32]), 64'h0000_0000_DE22_BE44);
    xfer(BASE + 32'h8, 1'b1, 32'h0, 4'b1111, 0);
    xfer(BASE + 32'h4, 1'b0, 32'h1234_5678, 4'b0000, 0);
    xfer(BASE + 32'hC, 1'b0, 32'h1, 4'b1111, 0);
    xfer(BASE + 32'hC, 1'b0, 32'h1, 4'b1111, 0);
    xfer(BASE + 32'h40, 1'b0, 32'hFFFF_FFFF, 4'b1111, 0);
    xfer(BASE + 32'h40, 1'b1, 32'h0, 4'b1111, 1);
    xfer(BASE - 32'h4, 1'b0, 32'hFFFF_FFFF, 4'b1111, 0);
    xfer(HIGH + 32'h1, 1'b1, 32'h0, 4'b1111, 0);
    xfer(BASE + 32'h1C, 1'b0, 32'hCAFE_F00D, 4'b1111, 2);
    xfer(BASE + 32'h1F, 1'b1, 32'h0, 4'b0000, 2);

    // Reset asserted during the ack cycle of a write: no ack, register stays at reset value
    abus = BASE + 32'h14; rnw = 1'b0; dbus = 32'h7777_7777; be = 4'b1111; sel = 1'b1;
    @(negedge clk);
    check_cycle("rm_c0", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_cycle("rm_c1", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0;
    @(negedge clk);
    check_cycle("rm_rel", 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    xfer(BASE + 32'h14, 1'b1, 32'h0, 4'b1111, 0);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      int cat;
      cat = $urandom_range(0, 9);
      if (cat < 6)      a = BASE + 32'(4 * $urandom_range(0, N - 1)) + 32'($urandom_range(0, 3));
      else if (cat < 8) a = BASE + 32'h20 + 32'(4 * $urandom_range(0, 55)) + 32'($urandom_range(0, 3));
      else if (cat < 9) a = BASE - 32'(1 + $urandom_range(0, 255));
      else              a = HIGH + 32'(1 + $urandom_range(0, 255));
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
